// File: rtl/wimax_pkg.sv
// Shared constants and bank state type for the WiMAX QPSK block interleaver.
package wimax_pkg;
  localparam int NCBPS = 192;
  localparam int D     = 16;
  localparam int ROWS  = NCBPS / D;

  typedef enum logic [1:0] {EMPTY, FILLING, FULL} bank_state_t;
endpackage

// File: rtl/interleaver_bank.sv
// One NCBPS-bit storage bank: synchronous single-bit write, combinational read.
module interleaver_bank
  import wimax_pkg::*;
(
  input  logic       clock,
  input  logic       we,
  input  logic [7:0] wr_addr,
  input  logic       wr_data,
  input  logic [7:0] rd_addr,
  output logic       rd_data
);
  logic [NCBPS-1:0] mem;

  always_ff @(posedge clock) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/wimax_interleaver.sv
// Ping-pong 802.16 first-permutation interleaver, 1 bit/cycle in and out.
// A block becomes readable the cycle after its last bit is written; input stalls only when both banks are full.
module wimax_interleaver
  import wimax_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic in_data,
  input  logic in_valid,
  output logic in_ready,
  output logic out_data,
  output logic out_valid,
  input  logic out_ready,
  output logic out_last
);
  bank_state_t state [2];
  logic        wr_sel;
  logic        rd_sel;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [7:0]  col_base;
  logic [7:0]  rd_cnt;
  logic [7:0]  wr_addr;
  logic        in_fire;
  logic        out_fire;
  logic        wr_last;
  logic        rd_last;
  logic [1:0]  rd_bit;

  assign in_ready  = (state[wr_sel] != FULL);
  assign out_valid = (state[rd_sel] == FULL);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign wr_last   = (col == 4'(D - 1)) && (row == 4'(ROWS - 1));
  assign rd_last   = (rd_cnt == 8'(NCBPS - 1));
  assign out_last  = out_valid && rd_last;
  assign out_data  = out_valid && rd_bit[rd_sel];

  // col_base tracks ROWS*col incrementally so the address needs only an adder.
  assign wr_addr = col_base + {4'd0, row};

  interleaver_bank u_bank0 (
    .clock   (clock),
    .we      (in_fire && !wr_sel),
    .wr_addr (wr_addr),
    .wr_data (in_data),
    .rd_addr (rd_cnt),
    .rd_data (rd_bit[0])
  );

  interleaver_bank u_bank1 (
    .clock   (clock),
    .we      (in_fire && wr_sel),
    .wr_addr (wr_addr),
    .wr_data (in_data),
    .rd_addr (rd_cnt),
    .rd_data (rd_bit[1])
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state[0] <= EMPTY;
      state[1] <= EMPTY;
      wr_sel   <= 1'b0;
      rd_sel   <= 1'b0;
      col      <= 4'd0;
      row      <= 4'd0;
      col_base <= 8'd0;
      rd_cnt   <= 8'd0;
    end else begin
      if (in_fire) begin
        if (col == 4'(D - 1)) begin
          col      <= 4'd0;
          col_base <= 8'd0;
          row      <= wr_last ? 4'd0 : row + 4'd1;
        end else begin
          col      <= col + 4'd1;
          col_base <= col_base + 8'(ROWS);
        end
        if (wr_last) wr_sel <= ~wr_sel;
      end
      if (out_fire) begin
        rd_cnt <= rd_last ? 8'd0 : rd_cnt + 8'd1;
        if (rd_last) rd_sel <= ~rd_sel;
      end
      // A bank is never written and read in the same cycle, so the two updates are exclusive.
      for (int i = 0; i < 2; i++) begin
        if (in_fire && wr_sel == 1'(i))
          state[i] <= wr_last ? FULL : FILLING;
        else if (out_fire && rd_last && rd_sel == 1'(i))
          state[i] <= EMPTY;
      end
    end
  end
endmodule
